// File: rtl/conv_encoder_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional codec.
package conv_encoder_pkg;
    localparam int unsigned K          = 7;
    localparam int unsigned TAIL_LEN   = 6;
    localparam int unsigned STATE_W    = 6;
    localparam logic [6:0]  G0_DEFAULT = 7'o171;
    localparam logic [6:0]  G1_DEFAULT = 7'o133;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_fsm_t;
endpackage

// File: rtl/conv_encoder_parity.sv
// One coded bit: XOR-reduction of the K-bit window masked by a generator polynomial.
module conv_parity (
    input  logic [6:0] window,
    input  logic [6:0] generator,
    output logic       parity
);
    assign parity = ^(window & generator);
endmodule

// File: rtl/conv_encoder.sv
// K=7 rate-1/2 convolutional encoder with frame-terminating zero tail and a
// single-entry valid/ready output register.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEFAULT,
    parameter logic [6:0] G1 = G1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_sym,
    output logic        out_last,
    output logic [5:0]  enc_state,
    output logic [15:0] frame_len
);
    enc_fsm_t           fsm;
    enc_fsm_t           fsm_next;
    logic [STATE_W-1:0] s;
    logic [2:0]         tail_cnt;
    logic               can_load;
    logic               in_xfer;
    logic               tail_step;
    logic               tail_done;
    logic               u;
    logic               c0;
    logic               c1;
    logic [6:0]         window;

    // The output register can take a new symbol when empty or being drained this cycle.
    assign can_load  = !out_valid || out_ready;
    assign in_ready  = !rst && (fsm == IDLE || fsm == DATA) && can_load;
    assign in_xfer   = in_valid && in_ready;
    assign tail_step = (fsm == TAIL) && can_load;
    assign tail_done = tail_step && (tail_cnt == 3'(TAIL_LEN - 1));
    assign u         = (fsm == TAIL) ? 1'b0 : in_bit;
    assign window    = {u, s};
    assign enc_state = s;

    conv_parity u_parity_c0 (
        .window    (window),
        .generator (G0),
        .parity    (c0)
    );

    conv_parity u_parity_c1 (
        .window    (window),
        .generator (G1),
        .parity    (c1)
    );

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE, DATA: if (in_xfer) fsm_next = in_last ? TAIL : DATA;
            TAIL:       if (tail_done) fsm_next = IDLE;
            default:    fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            tail_cnt  <= '0;
            frame_len <= '0;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            if (in_xfer || tail_step) begin
                out_sym   <= {c0, c1};
                out_valid <= 1'b1;
                out_last  <= tail_done;
                s         <= tail_done ? '0 : {u, s[STATE_W-1:1]};
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (tail_step)
                tail_cnt <= tail_done ? '0 : tail_cnt + 3'd1;

            // A transfer seen in IDLE always opens a new frame.
            if (in_xfer) begin
                if (fsm == IDLE)
                    frame_len <= 16'd1;
                else if (frame_len != 16'hFFFF)
                    frame_len <= frame_len + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// Directed and randomized checks of conv_encoder against a K=7 reference encoder.
module tb_conv_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sym;
    logic        out_last;
    logic [5:0]  enc_state;
    logic [15:0] frame_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_encoder #(.G0(7'o171), .G1(7'o133)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .enc_state (enc_state),
        .frame_len (frame_len)
    );

    typedef struct {
        logic        iv, ib, il, ordy;
        logic        ov;
        logic [1:0]  sym;
        logic        ol, ir;
        logic [5:0]  st;
        logic [15:0] fl;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    logic [5:0] mst;
    bit         rnd_ready;
    bit         fbits[200];
    logic [1:0] imp_sym[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic vec_t mk(logic iv, logic ib, logic il, logic ordy, logic ov,
                                logic [1:0] sym, logic ol, logic ir, logic [5:0] st, logic [15:0] fl);
        vec_t v;
        v.iv = iv; v.ib = ib; v.il = il; v.ordy = ordy; v.ov = ov;
        v.sym = sym; v.ol = ol; v.ir = ir; v.st = st; v.fl = fl;
        return v;
    endfunction

    // Reference: window bit 6 = current input, bit 0 = oldest state bit.
    function automatic logic [1:0] ref_sym(logic u, logic [5:0] st);
        logic [6:0] w;
        logic [6:0] g0;
        logic [6:0] g1;
        logic a;
        logic b;
        w = {u, st};
        g0 = 7'b1111001;
        g1 = 7'b1011011;
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a = a ^ (w[i] & g0[i]);
            b = b ^ (w[i] & g1[i]);
        end
        return {a, b};
    endfunction

    always @(negedge clk) begin
        logic lst;
        if (rst) begin
            exp_q.delete();
            obs_q.delete();
            mst = '0;
        end else begin
            if (out_valid && out_ready) obs_q.push_back({out_last, out_sym});
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, ref_sym(in_bit, mst)});
                mst = {in_bit, mst[5:1]};
                if (in_last) begin
                    for (int k = 0; k < 6; k++) begin
                        lst = (k == 5);
                        exp_q.push_back({lst, ref_sym(1'b0, mst)});
                        mst = {1'b0, mst[5:1]};
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send_frame(input int n, input bit rnd_valid, input bit with_last, output int first_wait);
        int guard;
        first_wait = 0;
        for (int i = 0; i < n; i++) begin
            if (rnd_valid) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_bit   = fbits[i];
            in_last  = with_last && (i == n - 1);
            guard = 0;
            while (!in_ready && guard < 1000) begin
                tick();
                guard++;
                if (i == 0) first_wait++;
            end
            if (guard >= 1000) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((obs_q.size() != exp_q.size() || out_valid) && guard < 3000) begin
            tick();
            guard++;
        end
        chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_sym%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w;
        int         n;
        int         guard;
        logic [1:0] held;
        logic [5:0] st_before;
        logic [1:0] tail_imp[6];
        tail_imp = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        imp_sym  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; rnd_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_enc_state", 32'(enc_state), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_out_sym",   32'(out_sym),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Impulse frame {1}, then an all-zero 8-bit frame.
        vecs.push_back(mk(1, 1, 1, 1, 1, 2'b11, 0, 0, 6'h20, 16'd1));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 0, 0, 1, 1, tail_imp[k], (k == 5), (k == 5), 6'(6'h20 >> (k + 1)), 16'd1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 1, 6'd0, 16'd1));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, (k == 7), 1, 1, 2'b00, 0, (k < 7), 6'd0, 16'(k + 1)));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, (k == 5), (k == 5), 6'd0, 16'd8));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 1, 6'd0, 16'd8));

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; in_bit = vecs[i].ib; in_last = vecs[i].il; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_out_sym", i),  32'(out_sym),  32'(vecs[i].sym));
                chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(vecs[i].ol));
            end
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
            chk($sformatf("vec%0d_enc_state", i), 32'(enc_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_frame_len", i), 32'(frame_len), 32'(vecs[i].fl));
        end
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        drain("table");

        // Backpressure: 3-cycle stall in the middle of an 8-bit frame.
        fbits[0] = 1; fbits[1] = 1; fbits[2] = 0; fbits[3] = 1;
        send_frame(4, 0, 0, w);
        out_ready = 1'b0; in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b0;
        #1;
        held = out_sym;
        st_before = enc_state;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_out_sym", c),   32'(out_sym),   32'(held));
            chk($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_in_ready", c),  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        tick();
        chk("idle_data_enc_state", 32'(enc_state), 32'(st_before));
        chk("idle_data_out_valid", 32'(out_valid), 32'd0);
        fbits[0] = 0; fbits[1] = 0; fbits[2] = 1; fbits[3] = 1;
        send_frame(4, 0, 1, w);
        drain("backpressure");
        chk("bp_frame_len", 32'(frame_len), 32'd8);

        // Back-to-back frames: second frame waits out the 6-symbol tail.
        fbits[0] = 1; fbits[1] = 0; fbits[2] = 1;
        send_frame(3, 0, 1, w);
        fbits[0] = 1; fbits[1] = 1; fbits[2] = 0; fbits[3] = 1;
        send_frame(4, 0, 1, w);
        chk("b2b_tail_wait", 32'(w), 32'd6);
        drain("b2b");
        chk("b2b_frame_len", 32'(frame_len), 32'd4);

        // Reset after 3 of 10 bits, then the impulse frame again.
        for (int i = 0; i < 10; i++) fbits[i] = 1'($urandom_range(0, 1));
        send_frame(3, 0, 0, w);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        chk("midrst_enc_state", 32'(enc_state), 32'd0);
        chk("midrst_frame_len", 32'(frame_len), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        fbits[0] = 1;
        send_frame(1, 0, 1, w);
        guard = 0;
        while ((obs_q.size() < 7 || out_valid) && guard < 100) begin
            tick();
            guard++;
        end
        chk("post_rst_count", 32'(obs_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < obs_q.size(); i++)
            chk($sformatf("post_rst_imp%0d", i), 32'(obs_q[i]), 32'({(i == 6), imp_sym[i]}));
        chk("post_rst_enc_state", 32'(enc_state), 32'd0);
        drain("post_rst");

        // Random frames with random valid gaps and random out_ready.
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            n = (f == 0) ? 1 : $urandom_range(1, 200);
            for (int i = 0; i < n; i++) fbits[i] = 1'($urandom_range(0, 1));
            send_frame(n, 1, 1, w);
            drain($sformatf("rand%0d", f));
            chk($sformatf("rand%0d_frame_len", f), 32'(frame_len), 32'(n));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
